// File: rtl/secuenciador_escritura.sv
// secuenciador_escritura: address/data byte sequencer for register writes; ESCRITURA_RANGO_EN enables the sticky range-error flag
module secuenciador_escritura #(
  parameter int                 N_REG          = 9,
  parameter int                 CW             = 7,
  parameter logic [N_REG*8-1:0] ADDR_TABLE     = {8'd65,8'd66,8'd67,8'd38,8'd37,8'd36,8'd33,8'd34,8'd35},
  parameter logic [N_REG-1:0]   ONE_BASED_MASK = 9'b000011000,
  parameter logic [7:0]         PROG_ADDR      = 8'hF0,
  parameter logic [7:0]         PROG_DATA      = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  prog,
  input  logic                  pausa,
  input  logic [N_REG*CW-1:0]   valores,
  input  logic                  ack,
  output logic [7:0]            salida_e,
  output logic                  A_D,
  output logic                  valid,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            indice,
  output logic                  err
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, FIN} state_t;
  localparam logic [3:0] LAST = 4'(N_REG - 1);
  state_t              state_q;
  logic [N_REG*CW-1:0] vals_q;
  logic                prog_q;
  logic [3:0]          idx_q;
  logic [7:0]          salida_q;
  logic                ad_q, valid_q, busy_q, done_q, err_q;
  logic [CW-1:0]       val_d;
  logic [CW:0]         v_d;
  logic                ovf_d;
  logic [7:0]          data_d, addr_d;
  logic [3:0]          idx_n_d;
  always_comb begin
    val_d   = vals_q[int'(idx_q)*CW +: CW];
    v_d     = {1'b0, val_d} + {{CW{1'b0}}, ONE_BASED_MASK[idx_q]};
    ovf_d   = v_d > (CW+1)'(99);
    data_d  = ovf_d ? 8'hFF : {4'(v_d / (CW+1)'(10)), 4'(v_d % (CW+1)'(10))};
    idx_n_d = idx_q == LAST ? idx_q : idx_q + 4'd1;
    addr_d  = ADDR_TABLE[int'(idx_n_d)*8 +: 8];
  end
  // Outputs are registered: each transition loads the byte for the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vals_q   <= '0;
      prog_q   <= 1'b0;
      idx_q    <= '0;
      salida_q <= 8'hFF;
      ad_q     <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (!pausa) begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q  <= ADDR;
          vals_q   <= valores;
          prog_q   <= prog;
          idx_q    <= '0;
          salida_q <= prog ? PROG_ADDR : ADDR_TABLE[7:0];
          ad_q     <= 1'b0;
          valid_q  <= 1'b1;
          busy_q   <= 1'b1;
          err_q    <= 1'b0;
        end
        ADDR: if (ack) begin
          state_q  <= DATA;
          ad_q     <= 1'b1;
          salida_q <= prog_q ? PROG_DATA : data_d;
`ifdef ESCRITURA_RANGO_EN
          err_q    <= err_q | (ovf_d & ~prog_q);
`endif
        end
        DATA: if (ack) begin
          if (prog_q || idx_q == LAST) begin
            state_q  <= FIN;
            salida_q <= 8'hFF;
            ad_q     <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            state_q  <= ADDR;
            idx_q    <= idx_n_d;
            salida_q <= addr_d;
            ad_q     <= 1'b0;
          end
        end
        FIN: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign salida_e = salida_q;
  assign A_D      = ad_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign indice   = idx_q;
  assign err      = err_q;
endmodule
